// File: rtl/he_ct_tensor.sv
// he_ct_tensor: degree-1 ciphertext add / degree-2 tensor product over Z_q[x]/(x^N+1).
// One (i,j) coefficient pair is processed per cycle in multiply mode; negacyclic
// wrap-around is handled by subtracting products whose index sum reaches N.
module he_ct_tensor #(
    parameter int unsigned DEGREE_N  = 4,
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [BIT_WIDTH-1:0]                       q,
    input  logic                                       mode_i,
    input  logic                                       start_i,
    input  logic [DEGREE_N-1:0][BIT_WIDTH-1:0]         ct00,
    input  logic [DEGREE_N-1:0][BIT_WIDTH-1:0]         ct01,
    input  logic [DEGREE_N-1:0][BIT_WIDTH-1:0]         ct10,
    input  logic [DEGREE_N-1:0][BIT_WIDTH-1:0]         ct11,
    output logic                                       ready_o,
    output logic                                       valid_o,
    output logic [2:0][DEGREE_N-1:0][BIT_WIDTH-1:0]    res
);

    localparam int unsigned N  = DEGREE_N;
    localparam int unsigned W  = BIT_WIDTH;
    localparam int unsigned LN = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;

    localparam logic [LN-1:0] LAST_IDX = LN'(N - 1);
    localparam logic [LN-1:0] ONE_IDX  = LN'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAdd,
        StMul,
        StDone
    } state_e;

    typedef logic [N-1:0][W-1:0] poly_t;

    state_e        state_q, state_d;
    logic [W-1:0]  q_q;
    logic          mode_q;
    poly_t         a0_q, a1_q, b0_q, b1_q;
    poly_t         acc0_q, acc1_q, acc2_q;
    poly_t         acc0_nxt, acc1_nxt, acc2_nxt;
    logic [LN-1:0] i_q, j_q;
    logic [2:0][N-1:0][W-1:0] res_q;
    logic          ready_q, valid_q;

    // Modular helpers: sums stay W+1 bits, products 2W bits.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] m);
        logic [W:0] s;
        if (y == '0) return x;
        s = {1'b0, x} + {1'b0, m} - {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        p = p % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_red(input logic [W-1:0] x, input logic [W-1:0] m);
        return x % m;
    endfunction

    logic [W-1:0] a0_i, a1_i, b0_j, b1_j;
    logic [W-1:0] p00, p01, p11;
    logic [LN:0]  sum_ij;
    logic [LN-1:0] k_idx;
    logic         wrap;
    logic         last_pair;

    // Per-cycle tensor step: products for the current (i,j) folded into index k.
    always_comb begin
        a0_i      = a0_q[i_q];
        a1_i      = a1_q[i_q];
        b0_j      = b0_q[j_q];
        b1_j      = b1_q[j_q];
        p00       = mod_mul(a0_i, b0_j, q_q);
        p01       = mod_add(mod_mul(a0_i, b1_j, q_q), mod_mul(a1_i, b0_j, q_q), q_q);
        p11       = mod_mul(a1_i, b1_j, q_q);
        sum_ij    = {1'b0, i_q} + {1'b0, j_q};
        k_idx     = sum_ij[LN-1:0];
        // N is a power of two, so the carry out of the index sum marks x^N wrap
        wrap      = (N > 1) ? sum_ij[LN] : 1'b1;
        last_pair = (i_q == LAST_IDX) && (j_q == LAST_IDX);
        acc0_nxt  = acc0_q;
        acc1_nxt  = acc1_q;
        acc2_nxt  = acc2_q;
        if (wrap) begin
            acc0_nxt[k_idx] = mod_sub(acc0_q[k_idx], p00, q_q);
            acc1_nxt[k_idx] = mod_sub(acc1_q[k_idx], p01, q_q);
            acc2_nxt[k_idx] = mod_sub(acc2_q[k_idx], p11, q_q);
        end else begin
            acc0_nxt[k_idx] = mod_add(acc0_q[k_idx], p00, q_q);
            acc1_nxt[k_idx] = mod_add(acc1_q[k_idx], p01, q_q);
            acc2_nxt[k_idx] = mod_add(acc2_q[k_idx], p11, q_q);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StLoad;
            StLoad: state_d = mode_q ? StMul : StAdd;
            StAdd:  state_d = StDone;
            StMul:  if (last_pair) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == StIdle);
            valid_q <= (state_d == StDone);
        end
    end

    // Datapath: operand capture, in-place reduction, accumulation and result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            mode_q <= 1'b0;
            a0_q   <= '0;
            a1_q   <= '0;
            b0_q   <= '0;
            b1_q   <= '0;
            acc0_q <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            res_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        q_q    <= q;
                        mode_q <= mode_i;
                        a0_q   <= ct00;
                        a1_q   <= ct01;
                        b0_q   <= ct10;
                        b1_q   <= ct11;
                    end
                end
                StLoad: begin
                    for (int unsigned k = 0; k < N; k++) begin
                        a0_q[k] <= mod_red(a0_q[k], q_q);
                        a1_q[k] <= mod_red(a1_q[k], q_q);
                        b0_q[k] <= mod_red(b0_q[k], q_q);
                        b1_q[k] <= mod_red(b1_q[k], q_q);
                    end
                    acc0_q <= '0;
                    acc1_q <= '0;
                    acc2_q <= '0;
                    i_q    <= '0;
                    j_q    <= '0;
                end
                StAdd: begin
                    for (int unsigned k = 0; k < N; k++) begin
                        res_q[0][k] <= mod_add(a0_q[k], b0_q[k], q_q);
                        res_q[1][k] <= mod_add(a1_q[k], b1_q[k], q_q);
                    end
                    res_q[2] <= '0;
                end
                StMul: begin
                    acc0_q <= acc0_nxt;
                    acc1_q <= acc1_nxt;
                    acc2_q <= acc2_nxt;
                    if (i_q == LAST_IDX) begin
                        i_q <= '0;
                        j_q <= j_q + ONE_IDX;
                    end else begin
                        i_q <= i_q + ONE_IDX;
                    end
                    if (last_pair) begin
                        res_q[0] <= acc0_nxt;
                        res_q[1] <= acc1_nxt;
                        res_q[2] <= acc2_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign res     = res_q;

endmodule

// File: tb/tb_he_ct_tensor.sv
// Directed bench for he_ct_tensor (N=4, W=16) with hand-computed expectations.
module tb_he_ct_tensor;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [15:0]           q;
    logic                  mode_i;
    logic                  start_i;
    logic [3:0][15:0]      ct00, ct01, ct10, ct11;
    logic                  ready_o;
    logic                  valid_o;
    logic [2:0][3:0][15:0] res;

    int vectors = 0;
    int errors  = 0;

    he_ct_tensor #(
        .DEGREE_N (4),
        .BIT_WIDTH(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .q      (q),
        .mode_i (mode_i),
        .start_i(start_i),
        .ct00   (ct00),
        .ct01   (ct01),
        .ct10   (ct10),
        .ct11   (ct11),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .res    (res)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][15:0] fill(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // Index 0 first.
    function automatic logic [3:0][15:0] poly(input logic [15:0] c0, input logic [15:0] c1,
                                              input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Drive one accepted start; returns just after the accepting edge.
    task automatic launch(input logic m, input logic [15:0] qv,
                          input logic [3:0][15:0] c00, input logic [3:0][15:0] c01,
                          input logic [3:0][15:0] c10, input logic [3:0][15:0] c11);
        q       = qv;
        mode_i  = m;
        ct00    = c00;
        ct01    = c01;
        ct10    = c10;
        ct11    = c11;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Bounded wait for valid_o; n counts edges after the accepting edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ready_o);
        end
        vectors++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        vectors++;
        if (res !== '0) begin
            errors++;
            $display("FAIL reset_res: got %h want 0", res);
        end
    endtask

    task automatic test_add();
        int n;
        logic [2:0][3:0][15:0] e;
        e[0] = fill(16'd4);
        e[1] = fill(16'd6);
        e[2] = '0;
        launch(1'b0, 16'd97, fill(16'd1), fill(16'd2), fill(16'd3), fill(16'd4));
        vectors++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL add_ready_drop: got %b want 0", ready_o);
        end
        wait_valid(n);
        vectors++;
        if (n !== 2) begin
            errors++;
            $display("FAIL add_latency: got %0d want 2", n);
        end
        vectors++;
        if (res !== e) begin
            errors++;
            $display("FAIL add_res: got %h want %h", res, e);
        end
        tick();
        vectors++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL add_after_valid: got valid=%b ready=%b want valid=0 ready=1",
                     valid_o, ready_o);
        end
    endtask

    task automatic test_mul();
        int n;
        logic [2:0][3:0][15:0] e;
        e[0] = poly(16'd91, 16'd0, 16'd6, 16'd12);
        e[1] = poly(16'd77, 16'd0, 16'd20, 16'd40);
        e[2] = poly(16'd81, 16'd0, 16'd16, 16'd32);
        launch(1'b1, 16'd97, fill(16'd1), fill(16'd2), fill(16'd3), fill(16'd4));
        wait_valid(n);
        vectors++;
        if (n !== 17) begin
            errors++;
            $display("FAIL mul_latency: got %0d want 17", n);
        end
        vectors++;
        if (res !== e) begin
            errors++;
            $display("FAIL mul_res: got %h want %h", res, e);
        end
        tick();
        vectors++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_after_valid: got valid=%b ready=%b want valid=0 ready=1",
                     valid_o, ready_o);
        end
    endtask

    task automatic test_input_reduction();
        int n;
        logic [2:0][3:0][15:0] e;
        e = '0;
        launch(1'b0, 16'd7, fill(16'd9), '0, fill(16'd12), '0);
        wait_valid(n);
        vectors++;
        if (n !== 2 || res !== e) begin
            errors++;
            $display("FAIL red_add: got n=%0d res=%h want n=2 res=%h", n, res, e);
        end
        tick();
        e[0] = poly(16'd3, 16'd0, 16'd4, 16'd1);
        launch(1'b1, 16'd7, fill(16'd9), '0, fill(16'd1), '0);
        wait_valid(n);
        vectors++;
        if (n !== 17 || res !== e) begin
            errors++;
            $display("FAIL red_mul: got n=%0d res=%h want n=17 res=%h", n, res, e);
        end
        tick();
    endtask

    task automatic test_busy_start();
        int n;
        int extra;
        logic [2:0][3:0][15:0] e;
        e[0] = poly(16'd91, 16'd0, 16'd6, 16'd12);
        e[1] = poly(16'd77, 16'd0, 16'd20, 16'd40);
        e[2] = poly(16'd81, 16'd0, 16'd16, 16'd32);
        launch(1'b1, 16'd97, fill(16'd1), fill(16'd2), fill(16'd3), fill(16'd4));
        for (int c = 0; c < 5; c++) tick();
        ct00    = fill(16'd50);
        ct11    = fill(16'd33);
        mode_i  = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_valid(n);
        vectors++;
        if (n !== 11) begin
            errors++;
            $display("FAIL busy_latency: got %0d want 11", n);
        end
        vectors++;
        if (res !== e) begin
            errors++;
            $display("FAIL busy_res: got %h want %h", res, e);
        end
        extra = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (valid_o) extra++;
        end
        vectors++;
        if (extra !== 0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_extra_valid: got pulses=%0d ready=%b want pulses=0 ready=1",
                     extra, ready_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        int n;
        logic [2:0][3:0][15:0] e;
        launch(1'b1, 16'd97, fill(16'd1), fill(16'd2), fill(16'd3), fill(16'd4));
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags: got ready=%b valid=%b want ready=1 valid=0",
                     ready_o, valid_o);
        end
        vectors++;
        if (res !== '0) begin
            errors++;
            $display("FAIL rstmid_res: got %h want 0", res);
        end
        rst = 1'b0;
        e[0] = fill(16'd4);
        e[1] = fill(16'd6);
        e[2] = '0;
        launch(1'b0, 16'd97, fill(16'd1), fill(16'd2), fill(16'd3), fill(16'd4));
        wait_valid(n);
        vectors++;
        if (n !== 2 || res !== e) begin
            errors++;
            $display("FAIL rstmid_add: got n=%0d res=%h want n=2 res=%h", n, res, e);
        end
        tick();
    endtask

    task automatic test_boundary_mod();
        int n;
        int bad;
        logic [2:0][3:0][15:0] e;
        e[0] = poly(16'd65533, 16'd0, 16'd2, 16'd4);
        e[1] = poly(16'd65531, 16'd0, 16'd4, 16'd8);
        e[2] = poly(16'd65533, 16'd0, 16'd2, 16'd4);
        launch(1'b1, 16'hFFFF, fill(16'hFFFE), fill(16'hFFFE), fill(16'hFFFE), fill(16'hFFFE));
        wait_valid(n);
        vectors++;
        if (n !== 17 || res !== e) begin
            errors++;
            $display("FAIL boundary_res: got n=%0d res=%h want n=17 res=%h", n, res, e);
        end
        bad = 0;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 4; k++)
                if (res[p][k] >= 16'hFFFF) bad++;
        vectors++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL boundary_range: got %0d coefficients >= q want 0", bad);
        end
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        q       = '0;
        mode_i  = 1'b0;
        start_i = 1'b0;
        ct00    = '0;
        ct01    = '0;
        ct10    = '0;
        ct11    = '0;
        test_reset();
        test_add();
        test_mul();
        test_input_reduction();
        test_busy_start();
        test_reset_mid_mul();
        test_boundary_mod();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/he_ct_tensor.md
# he_ct_tensor

Parametrised ciphertext arithmetic engine for the HE datapath. It accepts two degree-1 ciphertexts (ct0 = (ct00, ct01), ct1 = (ct10, ct11)) whose coefficients are polynomials in Z_q[x]/(x^N+1). In add mode it returns their component-wise sum. In multiply mode it returns the full degree-2 tensor product (three polynomials). It is the next generation of the fixed-size `functional` multiplier: generic N and width, runtime add/mul mode, input reduction, a ready/start handshake and a third output polynomial.

## Interface
- DEGREE_N, 4, polynomial length N (power of two, ≥2)
- BIT_WIDTH, 16, coefficient width W
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- q  in  W  modulus, sampled on accepted start; legal range 2..2^W-1
- mode_i  in  1  0 = add, 1 = tensor multiply; sampled on accepted start
- start_i  in  1  request; accepted only when ready_o=1
- ct00, ct01, ct10, ct11  in  [N-1:0][W-1:0]  operand coefficients, index = power of x; sampled on accepted start
- ready_o  out  1  high in IDLE only
- valid_o  out  1  one-cycle pulse; res valid from this cycle until next accepted start
- res [2:0]  out  [N-1:0][W-1:0]  result polynomials, each coefficient in [0,q)

## Operation
- States: IDLE, LOAD, ADD, MUL, DONE.
- IDLE: ready_o=1. On start_i=1, latch q, mode and operands, then go to LOAD. start_i outside IDLE is ignored (no queueing).
- LOAD (1 cycle): reduce each latched coefficient mod q in place. Clear accumulators acc0..acc2 to 0. Next state: ADD if mode=0, else MUL.
- ADD (1 cycle): res0[k]=(a0[k]+b0[k]) mod q; res1[k]=(a1[k]+b1[k]) mod q; res2=0. Next state: DONE.
- MUL: counters j (outer, b index) and i (inner, a index), each 0..N-1; one (i,j) pair per cycle, N*N cycles total.
  - Per cycle, form four products mod q: p00=a0[i]*b0[j], p01=a0[i]*b1[j]+a1[i]*b0[j] (sum reduced mod q), p11=a1[i]*b1[j].
  - Target index k=(i+j) mod N.
  - If i+j<N: acc[k] += p (mod q). Otherwise acc[k] -= p (mod q), computed as acc+q-p when p≠0 (negacyclic wrap).
  - acc0 takes p00, acc1 takes p01, acc2 takes p11.
  - After the pair (i=N-1, j=N-1), copy acc0..acc2 to res[0..2] and go to DONE.
- DONE (1 cycle): valid_o=1. Next state: IDLE.
- Width rules:
  - Products are 2W bits wide, then reduced mod q.
  - Sums are W+1 bits wide; reduce by a single conditional subtract of q.
  - No intermediate value exceeds 2W+1 bits.
- res holds its value through IDLE. It is overwritten only when the next operation's result is committed: at the end of ADD or at the end of MUL.
- Reset (any state, including mid-MUL): state→IDLE, ready_o=1, valid_o=0, res/acc/counters→0. The in-flight operation is discarded with no valid_o.

## Timing
- Accepted start at edge E0 (LOAD entered at E0).
- Add: valid_o high in the cycle after edge E0+2 (3-cycle start-to-valid).
- Mul: valid_o high in the cycle after edge E0+1+N*N (N=4: E0+17).
- ready_o drops the cycle after E0 and returns the cycle after the valid_o cycle.
- Earliest back-to-back start: the first cycle with ready_o=1 after valid_o.
- All outputs are registered; no combinational input→output path.

## Test plan
- Add, q=97, ct00=all 1, ct01=all 2, ct10=all 3, ct11=all 4 → res0=all 4, res1=all 6, res2=all 0. valid_o pulses exactly once, 3 cycles after start.
- Mul, N=4, q=97, same operands → res0={91,0,6,12}, res1={77,0,20,40}, res2={81,0,16,32} (index 0 first). valid_o arrives 17 cycles after the start edge.
- Input reduction, add, q=7, ct00=all 9, ct10=all 12 → res0=all 0 (2+5=7→0). Mul with same q: ct00=all 9, ct10=all 1 → res0 equals 2×{−2,0,2,4} mod 7 = {3,0,4,1}.
- Start while busy: pulse start_i with new operands during MUL → ignored. res still matches the first operation; only one valid_o.
- Reset mid-MUL (rst at cycle 8 after start) → next cycle ready_o=1, valid_o=0, res all 0. A new add started afterwards completes normally.
- Boundary modulus q=2^W-1 with all coefficients q-1, mul → matches a reference model. No overflow; every output coefficient lies in [0,q).
